// File: rtl/mul_arb_pkg.sv
// Shared types and the round-robin pick function for the shared-multiplier arbiter.
package mul_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_PIPE  = 2;
    localparam int MAX_NREQ  = 8;
    localparam int MAX_IDW   = 3;

    // Stage record for the default configuration; mul_pipe builds its own sized copy.
    typedef struct packed {
        logic                     valid;
        logic [$clog2(DEF_NREQ)-1:0] id;
        logic [2*DEF_WIDTH-1:0]   prod;
    } mul_stage_t;

    // One-hot grant on the first set bit of req at or after (last+1) mod n.
    function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                    input int unsigned last,
                                                    input int unsigned n);
        logic [MAX_NREQ-1:0] gnt;
        logic                found;
        int unsigned         idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= n; k++) begin
            idx = (last + k) % n;
            if (!found && req[idx[MAX_IDW-1:0]]) begin
                gnt[idx[MAX_IDW-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Tagged unsigned multiply pipeline; all stages move together on adv_i.
module mul_pipe #(
    parameter int WIDTH = 4,
    parameter int PIPE  = 2,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv_i,
    input  logic               in_valid_i,
    input  logic [IDW-1:0]     in_id_i,
    input  logic [WIDTH-1:0]   in_a_i,
    input  logic [WIDTH-1:0]   in_b_i,
    output logic               out_valid_o,
    output logic [IDW-1:0]     out_id_o,
    output logic [2*WIDTH-1:0] out_data_o,
    output logic               busy_o
);

    typedef struct packed {
        logic               valid;
        logic [IDW-1:0]     id;
        logic [2*WIDTH-1:0] prod;
    } stage_t;

    stage_t stage_q [PIPE];
    stage_t stage_d [PIPE];

    // Zero-extend before multiplying so the full 2*WIDTH product is kept.
    always_comb begin
        stage_d[0].valid = in_valid_i;
        stage_d[0].id    = in_id_i;
        stage_d[0].prod  = {{WIDTH{1'b0}}, in_a_i} * {{WIDTH{1'b0}}, in_b_i};
        for (int s = 1; s < PIPE; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE; s++) begin
                stage_q[s] <= '0;
            end
        end else if (adv_i) begin
            for (int s = 0; s < PIPE; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < PIPE; s++) begin
            busy_o = busy_o | stage_q[s].valid;
        end
    end

    assign out_valid_o = stage_q[PIPE-1].valid;
    assign out_id_o    = stage_q[PIPE-1].id;
    assign out_data_o  = stage_q[PIPE-1].prod;

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter feeding one shared pipelined multiplier; products return tagged by requester.
module mul_rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int PIPE  = DEF_PIPE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_data,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]      last_q, last_d;
    logic [MAX_NREQ-1:0] req_ext;
    logic [MAX_NREQ-1:0] pick_full;
    logic                advance;
    logic                accept;
    logic [IDW-1:0]      gidx;
    logic [WIDTH-1:0]    sel_a, sel_b;

    // The whole pipeline stalls when its output is held, so grants stop too.
    assign advance = !rsp_valid || rsp_ready;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req_valid;
        pick_full          = rr_pick(req_ext, 32'(last_q), NREQ);
    end

    if (NREQ < MAX_NREQ) begin : g_pad
        logic pick_unused;
        assign pick_unused = |pick_full[MAX_NREQ-1:NREQ];
    end

    assign req_ready = (advance && !rst) ? pick_full[NREQ-1:0] : '0;
    assign accept    = |req_ready;

    always_comb begin
        gidx  = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gidx  = i[IDW-1:0];
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign last_d = accept ? gidx : last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

    mul_pipe #(
        .WIDTH (WIDTH),
        .PIPE  (PIPE),
        .IDW   (IDW)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .adv_i       (advance),
        .in_valid_i  (accept),
        .in_id_i     (gidx),
        .in_a_i      (sel_a),
        .in_b_i      (sel_b),
        .out_valid_o (rsp_valid),
        .out_id_o    (rsp_id),
        .out_data_o  (rsp_data),
        .busy_o      (busy)
    );

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter with an accept/retire scoreboard.
module tb_mul_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid, rsp_ready;
    logic [1:0]            rsp_id;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int prod;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mul_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on retire; reset drops everything in flight.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id   = i;
                    e.prod = int'(req_a[i*WIDTH +: WIDTH]) * int'(req_b[i*WIDTH +: WIDTH]);
                    sb.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", {30'd0, rsp_id}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id", {30'd0, rsp_id}, e.id);
                    chk("sb_data", {24'd0, rsp_data}, e.prod);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        logic [31:0] av, bv;
        av = a;
        bv = b;
        req_a[i*WIDTH +: WIDTH] = av[WIDTH-1:0];
        req_b[i*WIDTH +: WIDTH] = bv[WIDTH-1:0];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        step();
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req_ready", {28'd0, req_ready}, 0);

        // Single request with 2-cycle latency.
        rst       = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 3, 5);
        #1;
        chk("single_grant", {28'd0, req_ready}, 4'b0100);
        step();
        req_valid = '0;
        #1;
        chk("single_lat1_valid", {31'd0, rsp_valid}, 0);
        chk("single_lat1_busy", {31'd0, busy}, 1);
        step();
        chk("single_valid", {31'd0, rsp_valid}, 1);
        chk("single_id", {30'd0, rsp_id}, 2);
        chk("single_data", {24'd0, rsp_data}, 15);
        step();
        chk("single_one_cycle", {31'd0, rsp_valid}, 0);
        chk("single_idle_busy", {31'd0, busy}, 0);

        // Fairness under full load, back-to-back responses.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, i + 2);
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5) ? 4'hF : 4'h0;
            #1;
            if (k < 5) chk("rr_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
            if (k >= 2) begin
                chk("rr_rsp_valid", {31'd0, rsp_valid}, 1);
                chk("rr_rsp_id", {30'd0, rsp_id}, (k - 2) % 4);
            end
            step();
        end
        chk("rr_drained", {31'd0, busy}, 0);

        // Backpressure: output frozen and grants blocked while rsp_ready=0.
        do_reset();
        set_op(0, 7, 8);
        set_op(1, 9, 10);
        set_op(2, 15, 15);
        req_valid = 4'b0001;
        #1;
        chk("bp_grant0", {28'd0, req_ready}, 4'b0001);
        step();
        req_valid = 4'b0010;
        #1;
        chk("bp_grant1", {28'd0, req_ready}, 4'b0010);
        step();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_hold_valid", {31'd0, rsp_valid}, 1);
            chk("bp_hold_id", {30'd0, rsp_id}, 0);
            chk("bp_hold_data", {24'd0, rsp_data}, 56);
            chk("bp_no_grant", {28'd0, req_ready}, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", {28'd0, req_ready}, 4'b0100);
        step();
        req_valid = '0;
        #1;
        chk("bp_rsp1_id", {30'd0, rsp_id}, 1);
        step();
        chk("bp_rsp2_id", {30'd0, rsp_id}, 2);
        chk("bp_rsp2_data", {24'd0, rsp_data}, 225);
        step();
        chk("bp_drained", {31'd0, rsp_valid}, 0);

        // Wrap-around from last_grant=3 plus arithmetic corners.
        do_reset();
        set_op(0, 15, 15);
        set_op(3, 0, 9);
        req_valid = 4'b1001;
        #1;
        chk("wrap_first", {28'd0, req_ready}, 4'b0001);
        step();
        chk("wrap_second", {28'd0, req_ready}, 4'b1000);
        step();
        chk("wrap_third", {28'd0, req_ready}, 4'b0001);
        chk("wrap_rsp_data", {24'd0, rsp_data}, 225);
        step();
        req_valid = '0;
        #1;
        chk("zero_rsp_id", {30'd0, rsp_id}, 3);
        chk("zero_rsp_data", {24'd0, rsp_data}, 0);
        step();
        step();
        chk("wrap_drained", {31'd0, busy}, 0);

        // Reset with two entries in flight.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 3, 2);
        req_valid = 4'hF;
        step();
        step();
        chk("mid_inflight", {31'd0, rsp_valid}, 1);
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        step();
        chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("mid_first_grant", {28'd0, req_ready}, 4'b0001);
        step();
        req_valid = '0;
        step();
        step();
        step();
        chk("end_idle", {31'd0, busy}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
